// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one command byte to the mouse
// over open-collector PS2_CLK/PS2_DATA, driven through pull-low enables.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 10000,
    parameter int unsigned TIMEOUT_CYCLES = 1500000,
    parameter int unsigned CNT_W          = 21
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_START,
        S_XMIT,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0] clk_sync;
    logic [1:0] data_sync;
    logic       clk_prev;
    logic       clk_s;
    logic       data_s;
    logic       fall;

    state_t     state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [3:0] bit_cnt, bit_cnt_n;
    logic [9:0] shift, shift_n;
    logic       clk_oe_q, clk_oe_n;
    logic       data_oe_q, data_oe_n;
    logic       done;
    logic       err;

    // Idle bus level is high, so the synchronizers reset high to avoid
    // a phantom falling edge right after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk_in};
            data_sync <= {data_sync[0], ps2_data_in};
            clk_prev  <= clk_sync[1];
        end
    end

    assign clk_s  = clk_sync[1];
    assign data_s = data_sync[1];
    assign fall   = clk_prev & ~clk_s;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bit_cnt   <= bit_cnt_n;
            shift     <= shift_n;
            clk_oe_q  <= clk_oe_n;
            data_oe_q <= data_oe_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        clk_oe_n  = clk_oe_q;
        data_oe_n = data_oe_q;
        done      = 1'b0;
        err       = 1'b0;

        unique case (state)
            S_IDLE: begin
                cnt_n     = '0;
                bit_cnt_n = '0;
                clk_oe_n  = 1'b0;
                data_oe_n = 1'b0;
                if (tx_valid) begin
                    shift_n  = {1'b1, ~^tx_data, tx_data};
                    clk_oe_n = 1'b1;
                    state_n  = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (cnt == INH_LAST) begin
                    data_oe_n = 1'b1;
                    cnt_n     = '0;
                    state_n   = S_START;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_START: begin
                clk_oe_n = 1'b0;
                cnt_n    = '0;
                state_n  = S_XMIT;
            end
            S_XMIT: begin
                if (fall) begin
                    data_oe_n = ~shift[0];
                    shift_n   = {1'b0, shift[9:1]};
                    bit_cnt_n = bit_cnt + 4'd1;
                    cnt_n     = '0;
                    if (bit_cnt == 4'd9) begin
                        state_n = S_ACK;
                    end
                end else if (cnt == TMO_LAST) begin
                    err = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_ACK: begin
                if (fall) begin
                    cnt_n = '0;
                    if (data_s) begin
                        err = 1'b1;
                    end else begin
                        state_n = S_WAIT_IDLE;
                    end
                end else if (cnt == TMO_LAST) begin
                    err = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_WAIT_IDLE: begin
                if (clk_s && data_s) begin
                    done    = 1'b1;
                    cnt_n   = '0;
                    state_n = S_IDLE;
                end else if (fall) begin
                    cnt_n = '0;
                end else if (cnt == TMO_LAST) begin
                    err = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        if (err) begin
            state_n   = S_IDLE;
            cnt_n     = '0;
            clk_oe_n  = 1'b0;
            data_oe_n = 1'b0;
        end
    end

    assign tx_ready = (state == S_IDLE);
    assign tx_busy  = (state != S_IDLE);
    assign tx_done  = done;
    assign tx_err   = err;

    // An abort releases the lines in the same cycle the error is flagged.
    assign ps2_clk_oe  = clk_oe_q & ~err;
    assign ps2_data_oe = data_oe_q & ~err;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks the frame out and
// compares each line bit against a scoreboard of expected frame bits.
module tb_ps2_host_tx;

    localparam int INH = 40;
    localparam int TMO = 300;
    localparam int H   = 8;
    localparam int LIM = 2000;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_err;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       dev_clk;
    logic       dev_data;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int bad_cnt  = 0;
    bit exp_q[$];

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO),
        .CNT_W(10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx_busy(tx_busy),
        .tx_done(tx_done),
        .tx_err(tx_err),
        .ps2_clk_in(ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe)
    );

    always #5 clk = ~clk;

    assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    always @(negedge clk) begin
        if (tx_done === 1'b1) done_cnt++;
        if (tx_err === 1'b1) err_cnt++;
        if (tx_ready === 1'b1 && tx_busy === 1'b1) bad_cnt++;
        if (tx_done === 1'b1 && tx_err === 1'b1) bad_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic push_frame(input logic [7:0] d);
        for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
        exp_q.push_back(($countones(d) % 2 == 0) ? 1'b1 : 1'b0);
        exp_q.push_back(1'b1);
    endtask

    task automatic send(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        push_frame(d);
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // ack_mode: 0 = stop after the given edges, 1 = ack, 2 = nack
    task automatic dev_xfer(input int edges, input int ack_mode);
        int n;
        bit b;
        n = 0;
        while (ps2_clk_oe !== 1'b1 && n < LIM) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b0 && n < LIM) begin
            @(negedge clk);
            n++;
        end
        chk_cnt++;
        if (n !== INH) $display("FAIL inhibit_len: got %0d want %0d", n, INH);
        else pass_cnt++;
        n = 0;
        while (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b1 && n < LIM) begin
            @(negedge clk);
            n++;
        end
        chk_cnt++;
        if (n !== 1) $display("FAIL start_len: got %0d want 1", n);
        else pass_cnt++;
        chk_cnt++;
        if ({ps2_clk_oe, ps2_data_oe} !== 2'b01)
            $display("FAIL release: got %b want 01", {ps2_clk_oe, ps2_data_oe});
        else pass_cnt++;
        if (edges == 0) return;
        repeat (4) @(negedge clk);
        for (int e = 1; e <= edges; e++) begin
            dev_clk = 1'b0;
            repeat (H) @(negedge clk);
            chk_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL bit%0d: scoreboard empty", e);
            end else begin
                b = exp_q.pop_front();
                if (ps2_data_in !== b)
                    $display("FAIL bit%0d: got %b want %b", e, ps2_data_in, b);
                else pass_cnt++;
            end
            dev_clk = 1'b1;
            repeat (H) @(negedge clk);
        end
        if (edges == 10 && ack_mode != 0) begin
            if (ack_mode == 1) dev_data = 1'b0;
            repeat (2) @(negedge clk);
            dev_clk = 1'b0;
            repeat (H) @(negedge clk);
            dev_clk = 1'b1;
            repeat (2) @(negedge clk);
            dev_data = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_cnt++;
        if ({tx_ready, tx_busy, tx_done, tx_err} !== 4'b1000)
            $display("FAIL reset_status: got %b want 1000",
                     {tx_ready, tx_busy, tx_done, tx_err});
        else pass_cnt++;
        chk_cnt++;
        if ({ps2_clk_oe, ps2_data_oe} !== 2'b00)
            $display("FAIL reset_oe: got %b want 00", {ps2_clk_oe, ps2_data_oe});
        else pass_cnt++;
        rst = 1'b1;
        send(8'hF4);
        repeat (5) @(negedge clk);
        chk_cnt++;
        if (ps2_clk_oe !== 1'b1) $display("FAIL inhibit_oe: got %b want 1", ps2_clk_oe);
        else pass_cnt++;
        #2 rst = 1'b0;
        #1;
        chk_cnt++;
        if (ps2_clk_oe !== 1'b0)
            $display("FAIL reset_inhibit_async: got %b want 0", ps2_clk_oe);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_send(input logic [7:0] d);
        int n;
        int d0;
        int e0;
        d0 = done_cnt;
        e0 = err_cnt;
        send(d);
        dev_xfer(10, 1);
        n = 0;
        while (done_cnt == d0 && n < LIM) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk_cnt++;
        if (done_cnt - d0 !== 1) $display("FAIL done_pulses: got %0d want 1", done_cnt - d0);
        else pass_cnt++;
        chk_cnt++;
        if (err_cnt - e0 !== 0) $display("FAIL err_pulses: got %0d want 0", err_cnt - e0);
        else pass_cnt++;
        chk_cnt++;
        if (exp_q.size() !== 0) $display("FAIL sb_left: got %0d want 0", exp_q.size());
        else pass_cnt++;
        chk_cnt++;
        if (tx_ready !== 1'b1) $display("FAIL ready_after: got %b want 1", tx_ready);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int n;
        @(negedge clk);
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        push_frame(8'hFF);
        dev_xfer(10, 1);
        n = 0;
        while (tx_done !== 1'b1 && n < LIM) begin
            @(negedge clk);
            n++;
        end
        chk_cnt++;
        if (tx_done !== 1'b1 || tx_busy !== 1'b1)
            $display("FAIL b2b_done: got done=%b busy=%b want 1 1", tx_done, tx_busy);
        else pass_cnt++;
        push_frame(8'hFF);
        @(negedge clk);
        chk_cnt++;
        if ({tx_ready, tx_busy} !== 2'b10)
            $display("FAIL b2b_idle: got %b want 10", {tx_ready, tx_busy});
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if ({ps2_clk_oe, tx_busy, tx_ready} !== 3'b110)
            $display("FAIL b2b_restart: got %b want 110", {ps2_clk_oe, tx_busy, tx_ready});
        else pass_cnt++;
        tx_valid = 1'b0;
        dev_xfer(10, 1);
        n = 0;
        while (tx_done !== 1'b1 && n < LIM) begin
            @(negedge clk);
            n++;
        end
        chk_cnt++;
        if (tx_done !== 1'b1) $display("FAIL b2b_second_done: got %b want 1", tx_done);
        else pass_cnt++;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_silent();
        int n;
        send(8'hF4);
        dev_xfer(0, 0);
        n = 1;
        while (tx_err !== 1'b1 && n < TMO + 50) begin
            @(negedge clk);
            n++;
        end
        chk_cnt++;
        if (n !== TMO) $display("FAIL silent_timeout: got %0d want %0d", n, TMO);
        else pass_cnt++;
        chk_cnt++;
        if ({ps2_clk_oe, ps2_data_oe} !== 2'b00)
            $display("FAIL silent_oe: got %b want 00", {ps2_clk_oe, ps2_data_oe});
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if (tx_ready !== 1'b1) $display("FAIL silent_ready: got %b want 1", tx_ready);
        else pass_cnt++;
        exp_q.delete();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_nack();
        int n;
        int d0;
        int e0;
        d0 = done_cnt;
        e0 = err_cnt;
        send(8'hF3);
        dev_xfer(10, 2);
        n = 0;
        while (err_cnt == e0 && n < LIM) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        chk_cnt++;
        if (err_cnt - e0 !== 1) $display("FAIL nack_err: got %0d want 1", err_cnt - e0);
        else pass_cnt++;
        chk_cnt++;
        if (done_cnt - d0 !== 0) $display("FAIL nack_done: got %0d want 0", done_cnt - d0);
        else pass_cnt++;
    endtask

    task automatic test_stall();
        int n;
        send(8'hF4);
        dev_xfer(4, 0);
        dev_clk = 1'b0;
        n = 0;
        while (tx_err !== 1'b1 && n < TMO + 50) begin
            @(negedge clk);
            n++;
        end
        chk_cnt++;
        if (n !== TMO + 2) $display("FAIL stall_timeout: got %0d want %0d", n, TMO + 2);
        else pass_cnt++;
        dev_clk = 1'b1;
        exp_q.delete();
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset_xmit();
        send(8'hF4);
        dev_xfer(4, 0);
        chk_cnt++;
        if (ps2_data_oe !== 1'b1) $display("FAIL xmit_d3: got %b want 1", ps2_data_oe);
        else pass_cnt++;
        #2 rst = 1'b0;
        #1;
        chk_cnt++;
        if ({ps2_clk_oe, ps2_data_oe} !== 2'b00)
            $display("FAIL reset_xmit_async: got %b want 00", {ps2_clk_oe, ps2_data_oe});
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk_cnt++;
        if (tx_ready !== 1'b1) $display("FAIL reset_xmit_ready: got %b want 1", tx_ready);
        else pass_cnt++;
        repeat (3) @(negedge clk);
        test_send(8'hF4);
    endtask

    initial begin
        rst      = 1'b0;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        test_reset();
        test_send(8'hF4);
        test_back_to_back();
        test_silent();
        test_nack();
        test_stall();
        test_reset_xmit();
        chk_cnt++;
        if (bad_cnt !== 0) $display("FAIL overlap: got %0d want 0", bad_cnt);
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter: sends one command byte to the mouse (e.g. 0xF4 enable reporting, 0xFF reset, 0xF3 set sample rate) over the shared PS2_CLK/PS2_DATA lines.
- It is the opposite direction of the existing mouse receive path.
- Drives the lines open-collector via two pull-low enables; top-level converts them to inout tristates and arbitrates with the receiver (receiver ignores the bus while tx_busy).

Parameters:
- INHIBIT_CYCLES, 10000, clk cycles PS2_CLK is held low before the request (100 us at 100 MHz).
- TIMEOUT_CYCLES, 1500000, max clk cycles between consecutive PS2_CLK falling edges (and from request to first edge) before abort (15 ms at 100 MHz).
- CNT_W, 21, width of the shared inhibit/timeout counter; must hold max(INHIBIT_CYCLES, TIMEOUT_CYCLES).

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous, active-low reset.
- tx_data  in  8  command byte; sampled when tx_valid && tx_ready.
- tx_valid  in  1  request to send tx_data.
- tx_ready  out  1  high only in IDLE.
- tx_busy  out  1  high in every state except IDLE.
- tx_done  out  1  one-cycle pulse: byte acknowledged and bus idle.
- tx_err  out  1  one-cycle pulse: timeout or missing ack.
- ps2_clk_in  in  1  raw PS2_CLK line level (asynchronous).
- ps2_data_in  in  1  raw PS2_DATA line level (asynchronous).
- ps2_clk_oe  out  1  1 = pull PS2_CLK low, 0 = release.
- ps2_data_oe  out  1  1 = pull PS2_DATA low, 0 = release.

Behaviour:
- Inputs: 2-flop synchronizers on ps2_clk_in/ps2_data_in. A falling edge is sync_prev=1 && sync=0, detected one clk after the second flop.
- Reset (rst=0, async):
  - State IDLE; tx_ready=1, tx_busy=0, tx_done=0, tx_err=0.
  - ps2_clk_oe=0, ps2_data_oe=0; counter=0; bit_cnt=0.
  - Reset mid-transfer releases both lines immediately.
- Frame: shift register {stop=1, parity=~^data, data[7:0]}, sent LSB first. Odd parity: parity bit makes the total count of ones in data+parity odd.
- IDLE:
  - On tx_valid: latch the frame; counter=0; ps2_clk_oe=1; go to INHIBIT.
  - tx_valid while not IDLE is ignored; no queueing.
- INHIBIT:
  - ps2_clk_oe=1 for exactly INHIBIT_CYCLES clk cycles.
  - Then ps2_data_oe=1 (start bit) for one cycle while clock is still held, then ps2_clk_oe=0; counter=0; go to XMIT.
- XMIT:
  - On each PS2_CLK falling edge, present the next frame bit: ps2_data_oe = ~bit; bit_cnt++ and counter=0.
  - Edges 1..8 give d0..d7; edge 9 gives parity; edge 10 gives stop (ps2_data_oe=0).
  - After edge 10, go to ACK.
- ACK: on the next (11th) falling edge, sample synced data.
  - 0: go to WAIT_IDLE.
  - 1: error.
- WAIT_IDLE: when synced clk=1 and data=1, pulse tx_done and go to IDLE.
- Timeout:
  - In XMIT, ACK and WAIT_IDLE, counter increments each clk and clears on every PS2_CLK falling edge.
  - counter == TIMEOUT_CYCLES-1 is an error.
- Error: release both lines the same cycle, pulse tx_err, go to IDLE. tx_done and tx_err are never both high.
- Throughput: tx_ready returns high the cycle after the tx_done/tx_err pulse. A held tx_valid starts the next byte then.
- A falling edge coinciding with counter == TIMEOUT_CYCLES-1 counts as an edge, not a timeout.

Test Plan:
- Send 0xF4 against a device model (clock period 80 us, ack on edge 11):
  - ps2_clk_oe high exactly 10000 cycles, then data_oe=1, then clk released.
  - Line bits on falling edges 1..10: 0,0,1,0,1,1,1,1, parity 0, stop 1.
  - One tx_done pulse; tx_err=0.
- Send 0xFF with tx_valid held through completion:
  - Parity bit=1.
  - A second transfer starts the cycle after tx_done; busy/ready never both high.
- Silent device: after clk release, no edges. tx_err pulses at cycle 1500000 after release; both oe=0; tx_ready=1 next cycle.
- NACK: model leaves PS2_DATA high on edge 11 → tx_err pulse, no tx_done.
- Stall: model stops clocking after edge 5 → tx_err exactly TIMEOUT_CYCLES after edge 5's detection.
- Reset: assert rst=0 mid-XMIT (after edge 4) → ps2_clk_oe/ps2_data_oe drop asynchronously. After release: tx_ready=1, and a new 0xF4 send completes normally.
